// File: rtl/step_pulse_gen.sv
// Eight-channel STEP/DIR generator: integrates signed fixed-point speeds per channel and
// turns every change of the integer position into a timed STEP pulse with DIR setup.
module step_pulse_gen #(
    parameter int STEP_BIT  = 32,
    parameter int DIR_SETUP = 8,
    parameter int PULSE_HI  = 16,
    parameter int PULSE_LO  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_step,
    input  logic [63:0] speed_0,
    input  logic [63:0] speed_1,
    input  logic [63:0] speed_2,
    input  logic [63:0] speed_3,
    input  logic [63:0] speed_4,
    input  logic [63:0] speed_5,
    input  logic [63:0] speed_6,
    input  logic [63:0] speed_7,
    input  logic [2:0]  pos_sel,
    input  logic [31:0] pos_in,
    input  logic        pos_load,
    output logic [31:0] pos_out,
    input  logic        err_clear,
    output logic [7:0]  step,
    output logic [7:0]  dir,
    output logic [7:0]  overrun,
    output logic [7:0]  overspeed,
    output logic        active
);
    localparam int CNT_MAX = (DIR_SETUP > PULSE_HI) ?
                             ((DIR_SETUP > PULSE_LO) ? DIR_SETUP : PULSE_LO) :
                             ((PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] HI_LOAD    = CNT_W'(PULSE_HI - 1);
    localparam logic [CNT_W-1:0] LO_LOAD    = CNT_W'(PULSE_LO - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    function automatic logic speed_too_high(input logic [63:0] v);
        logic [63:0] mag;
        mag = v[63] ? (~v + 64'd1) : v;
        return (mag >> STEP_BIT) != 64'd0;
    endfunction

    function automatic logic [63:0] load_value(input logic [31:0] p);
        logic [63:0] ext;
        ext = {{32{p[31]}}, p};
        return ext << STEP_BIT;
    endfunction

    logic [7:0][63:0] speed_s;
    logic [7:0][31:0] pos_int_s;
    logic [7:0]       busy_s;
    logic [31:0]      pos_out_r;
    logic             active_r;

    assign speed_s   = {speed_7, speed_6, speed_5, speed_4, speed_3, speed_2, speed_1, speed_0};
    assign pos_out   = pos_out_r;
    assign active    = active_r;

    for (genvar n = 0; n < 8; n++) begin : g_ch
        state_t           state_r, state_nx_s;
        logic [CNT_W-1:0] cnt_r, cnt_nx_s;
        logic [63:0]      acc_r, acc_sum_s;
        logic             load_hit_s, event_s;
        logic             req_r, req_dir_r;
        logic             pend_r, pend_dir_r, pend_nx_s, pend_dir_nx_s;
        logic             dir_r, dir_nx_s, step_r, step_nx_s;
        logic             take_s, take_dir_s, drop_s;
        logic             overrun_r, overspeed_r, busy_nx_s;

        assign acc_sum_s  = acc_r + speed_s[n];
        assign event_s    = (acc_sum_s >> STEP_BIT) != (acc_r >> STEP_BIT);
        assign load_hit_s = pos_load && (pos_sel == 3'(n));

        assign pos_int_s[n] = 32'(acc_r >> STEP_BIT);
        assign busy_s[n]    = busy_nx_s;
        assign step[n]      = step_r;
        assign dir[n]       = dir_r;
        assign overrun[n]   = overrun_r;
        assign overspeed[n] = overspeed_r;

        // Accumulator and one-cycle step request; a position load pre-empts integration.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_r     <= 64'd0;
                req_r     <= 1'b0;
                req_dir_r <= 1'b0;
            end else if (load_hit_s) begin
                acc_r <= load_value(pos_in);
                req_r <= 1'b0;
            end else if (int_step) begin
                acc_r     <= acc_sum_s;
                req_r     <= event_s;
                req_dir_r <= ~speed_s[n][63];
            end else begin
                req_r <= 1'b0;
            end
        end

        // State register: pulse FSM, timer, DIR, pending slot and sticky flags.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r     <= ST_IDLE;
                cnt_r       <= {CNT_W{1'b0}};
                dir_r       <= 1'b0;
                step_r      <= 1'b0;
                pend_r      <= 1'b0;
                pend_dir_r  <= 1'b0;
                overrun_r   <= 1'b0;
                overspeed_r <= 1'b0;
            end else begin
                state_r     <= state_nx_s;
                cnt_r       <= cnt_nx_s;
                dir_r       <= dir_nx_s;
                step_r      <= step_nx_s;
                pend_r      <= pend_nx_s;
                pend_dir_r  <= pend_dir_nx_s;
                overrun_r   <= (overrun_r & ~err_clear) | drop_s;
                overspeed_r <= (overspeed_r & ~err_clear) | (int_step & speed_too_high(speed_s[n]));
            end
        end

        // Next state; a pending step is served before a fresh request, which then queues.
        always_comb begin
            state_nx_s    = state_r;
            cnt_nx_s      = cnt_r;
            dir_nx_s      = dir_r;
            pend_nx_s     = pend_r;
            pend_dir_nx_s = pend_dir_r;
            take_s        = 1'b0;
            take_dir_s    = dir_r;
            drop_s        = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pend_r) begin
                        take_s        = 1'b1;
                        take_dir_s    = pend_dir_r;
                        pend_nx_s     = req_r;
                        pend_dir_nx_s = req_dir_r;
                    end else if (req_r) begin
                        take_s     = 1'b1;
                        take_dir_s = req_dir_r;
                    end else begin
                        take_s = 1'b0;
                    end
                    if (!take_s) begin
                        state_nx_s = ST_IDLE;
                    end else if (take_dir_s == dir_r) begin
                        state_nx_s = ST_HIGH;
                        cnt_nx_s   = HI_LOAD;
                    end else begin
                        dir_nx_s   = take_dir_s;
                        state_nx_s = ST_SETUP;
                        cnt_nx_s   = SETUP_LOAD;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nx_s = ST_HIGH;
                        cnt_nx_s   = HI_LOAD;
                    end else begin
                        cnt_nx_s = cnt_r - CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nx_s = ST_LOW;
                        cnt_nx_s   = LO_LOAD;
                    end else begin
                        cnt_nx_s = cnt_r - CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        cnt_nx_s = cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end
            endcase
            if (state_r != ST_IDLE && req_r) begin
                if (pend_r) begin
                    drop_s = 1'b1;
                end else begin
                    pend_nx_s     = 1'b1;
                    pend_dir_nx_s = req_dir_r;
                end
            end else begin
                drop_s = 1'b0;
            end
        end

        // Output decode from the next state so STEP is a plain register.
        always_comb begin
            step_nx_s = (state_nx_s == ST_HIGH);
            busy_nx_s = (state_nx_s != ST_IDLE) | pend_nx_s;
        end
    end

    // Position readback and activity summary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_out_r <= 32'd0;
            active_r  <= 1'b0;
        end else begin
            pos_out_r <= pos_int_s[pos_sel];
            active_r  <= |busy_s;
        end
    end
endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: directed scenarios plus random traffic, all tracked by a
// timestamp-based model of when each channel's pulse window opens and closes.
module tb_step_pulse_gen;
    localparam int DS = 8;
    localparam int PH = 16;
    localparam int PL = 16;

    logic        clk = 1'b0;
    logic        rst, int_step, pos_load, err_clear;
    logic [2:0]  pos_sel;
    logic [31:0] pos_in;
    logic [63:0] spd [8];
    logic [31:0] pos_out;
    logic [7:0]  step, dir, overrun, overspeed;
    logic        active;
    logic [64:0] obs_bus, exp_bus;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] m_acc [8];
    logic [7:0]  m_req, m_rdir, m_pend, m_pdir, m_dir, m_ovr, m_ovs, exp_step, exp_dir;
    int          m_free [8];
    int          m_hi_from [8];
    int          m_hi_to [8];
    logic [31:0] m_pos;
    logic        exp_active;

    always #5 clk = ~clk;

    assign obs_bus = {step, dir, overrun, overspeed, active, pos_out};

    step_pulse_gen dut (
        .clk(clk), .rst(rst), .int_step(int_step),
        .speed_0(spd[0]), .speed_1(spd[1]), .speed_2(spd[2]), .speed_3(spd[3]),
        .speed_4(spd[4]), .speed_5(spd[5]), .speed_6(spd[6]), .speed_7(spd[7]),
        .pos_sel(pos_sel), .pos_in(pos_in), .pos_load(pos_load), .pos_out(pos_out),
        .err_clear(err_clear), .step(step), .dir(dir), .overrun(overrun),
        .overspeed(overspeed), .active(active)
    );

    // Model: a taken step books a window (optional DIR setup, high, low) ending at m_free.
    task automatic model_edge();
        logic [63:0] nxt;
        logic [7:0]  new_ovr, new_ovs;
        logic        d;
        longint      s;
        if (rst) begin
            for (int ch = 0; ch < 8; ch++) begin
                m_acc[ch] = 64'd0; m_free[ch] = 0; m_hi_from[ch] = 0; m_hi_to[ch] = -1;
            end
            {m_req, m_rdir, m_pend, m_pdir, m_dir, m_ovr, m_ovs} = 56'd0;
            m_pos = 32'd0;
        end else begin
            m_pos = m_acc[pos_sel][63:32];
            new_ovr = 8'd0;
            new_ovs = 8'd0;
            for (int ch = 0; ch < 8; ch++) begin
                if (cyc >= m_free[ch] && (m_pend[ch] || m_req[ch])) begin
                    if (m_pend[ch]) begin
                        d = m_pdir[ch]; m_pend[ch] = m_req[ch]; m_pdir[ch] = m_rdir[ch];
                    end else begin
                        d = m_rdir[ch];
                    end
                    m_hi_from[ch] = (d == m_dir[ch]) ? cyc + 1 : cyc + 1 + DS;
                    m_dir[ch]     = d;
                    m_hi_to[ch]   = m_hi_from[ch] + PH - 1;
                    m_free[ch]    = m_hi_to[ch] + PL + 1;
                end else if (m_req[ch]) begin
                    if (m_pend[ch]) new_ovr[ch] = 1'b1;
                    else begin m_pend[ch] = 1'b1; m_pdir[ch] = m_rdir[ch]; end
                end
                s = $signed(spd[ch]);
                if (int_step && (s >= 64'sh1_0000_0000 || s <= -64'sh1_0000_0000)) new_ovs[ch] = 1'b1;
                if (pos_load && pos_sel == 3'(ch)) begin
                    m_acc[ch] = {pos_in, 32'h0}; m_req[ch] = 1'b0;
                end else if (int_step) begin
                    nxt = m_acc[ch] + spd[ch];
                    m_req[ch]  = (nxt[63:32] != m_acc[ch][63:32]);
                    m_rdir[ch] = ~spd[ch][63];
                    m_acc[ch]  = nxt;
                end else begin
                    m_req[ch] = 1'b0;
                end
            end
            m_ovr = (m_ovr & ~{8{err_clear}}) | new_ovr;
            m_ovs = (m_ovs & ~{8{err_clear}}) | new_ovs;
        end
        cyc++;
        exp_active = 1'b0;
        for (int ch = 0; ch < 8; ch++) begin
            exp_step[ch] = (cyc >= m_hi_from[ch]) && (cyc <= m_hi_to[ch]);
            exp_dir[ch]  = m_dir[ch];
            if (cyc < m_free[ch] || m_pend[ch]) exp_active = 1'b1;
        end
        exp_bus = {exp_step, exp_dir, m_ovr, m_ovs, exp_active, m_pos};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; int_step = 1'b0; pos_load = 1'b0; err_clear = 1'b0;
        pos_sel = 3'd0; pos_in = 32'd0;
        for (int ch = 0; ch < 8; ch++) spd[ch] = 64'd0;
        tick(); tick();
        checks++;
        if ({step, dir, overrun, overspeed, active} !== 33'd0)
            begin errors++; $display("FAIL reset_outs got=%h want=0", {step, dir, overrun, overspeed, active}); end
        checks++;
        if (pos_out !== 32'd0) begin errors++; $display("FAIL reset_pos got=%h want=0", pos_out); end
        rst = 1'b0;
        tick();
        checks++;
        if (obs_bus !== exp_bus) begin errors++; $display("FAIL reset_track got=%h want=%h", obs_bus, exp_bus); end
    endtask

    task automatic test_dir_setup();
        int t_int[$];
        int rises[$];
        int dir_rise = -1;
        int hi = 0;
        logic p_step, p_dir;
        spd[0] = 64'h0000_0000_8000_0000;
        p_step = step[0]; p_dir = dir[0];
        for (int k = 0; k < 170; k++) begin
            int_step = (k % 40 == 0) && (k < 160);
            if (int_step) t_int.push_back(cyc);
            tick();
            checks++;
            if (obs_bus !== exp_bus) begin errors++; $display("FAIL t1_track cyc=%0d got=%h want=%h", cyc, obs_bus, exp_bus); end
            if (step[0] && !p_step) rises.push_back(cyc);
            if (dir[0] && !p_dir) dir_rise = cyc;
            if (step[0]) hi++;
            p_step = step[0]; p_dir = dir[0];
        end
        int_step = 1'b0;
        checks++;
        if (rises.size() != 2) begin errors++; $display("FAIL t1_pulses got=%0d want=2", rises.size()); end
        checks++;
        if (hi != 2 * PH) begin errors++; $display("FAIL t1_high_cycles got=%0d want=%0d", hi, 2 * PH); end
        checks++;
        if (dir_rise != t_int[1] + 2) begin errors++; $display("FAIL t1_dir_rise got=%0d want=%0d", dir_rise, t_int[1] + 2); end
        checks++;
        if (rises.size() < 1 || rises[0] != t_int[1] + 2 + DS)
            begin errors++; $display("FAIL t1_first_rise got=%0d want=%0d", (rises.size() > 0) ? rises[0] : -1, t_int[1] + 2 + DS); end
        checks++;
        if (rises.size() < 2 || rises[1] != t_int[3] + 2)
            begin errors++; $display("FAIL t1_second_rise got=%0d want=%0d", (rises.size() > 1) ? rises[1] : -1, t_int[3] + 2); end
        checks++;
        if (pos_out !== 32'd2) begin errors++; $display("FAIL t1_pos got=%h want=2", pos_out); end
    endtask

    task automatic test_reverse();
        int t0 = -1;
        int dir_fall = -1;
        int rise = -1;
        logic p_step, p_dir;
        spd[0] = 64'hFFFF_FFFF_8000_0000;
        p_step = step[0]; p_dir = dir[0];
        for (int k = 0; k < 60; k++) begin
            int_step = (k == 0) || (k == 6);
            if (k == 0) t0 = cyc;
            tick();
            checks++;
            if (obs_bus !== exp_bus) begin errors++; $display("FAIL t2_track cyc=%0d got=%h want=%h", cyc, obs_bus, exp_bus); end
            if (!dir[0] && p_dir) dir_fall = cyc;
            if (step[0] && !p_step) rise = cyc;
            p_step = step[0]; p_dir = dir[0];
        end
        int_step = 1'b0; spd[0] = 64'd0;
        checks++;
        if (dir_fall != t0 + 2) begin errors++; $display("FAIL t2_dir_fall got=%0d want=%0d", dir_fall, t0 + 2); end
        checks++;
        if (rise != dir_fall + DS) begin errors++; $display("FAIL t2_setup got=%0d want=%0d", rise, dir_fall + DS); end
        checks++;
        if (pos_out !== 32'd1) begin errors++; $display("FAIL t2_pos got=%h want=1", pos_out); end
    endtask

    task automatic test_back_to_back();
        int rises = 0;
        logic p_step;
        // 0xFFFF_FFFF is just under one step: four strobes reach integer 3 with three events.
        spd[3] = 64'h0000_0000_FFFF_FFFF; pos_sel = 3'd3;
        p_step = step[3];
        for (int k = 0; k < 95; k++) begin
            int_step = (k < 4);
            tick();
            checks++;
            if (obs_bus !== exp_bus) begin errors++; $display("FAIL t3_track cyc=%0d got=%h want=%h", cyc, obs_bus, exp_bus); end
            if (step[3] && !p_step) rises++;
            p_step = step[3];
        end
        int_step = 1'b0; spd[3] = 64'd0;
        checks++;
        if (rises != 2) begin errors++; $display("FAIL t3_pulses got=%0d want=2", rises); end
        checks++;
        if (overrun[3] !== 1'b1) begin errors++; $display("FAIL t3_overrun got=%b want=1", overrun[3]); end
        checks++;
        if (pos_out !== 32'd3) begin errors++; $display("FAIL t3_pos got=%h want=3", pos_out); end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (overrun[3] !== 1'b0) begin errors++; $display("FAIL t3_clear got=%b want=0", overrun[3]); end
    endtask

    task automatic test_overspeed();
        int rises = 0;
        logic p_step;
        spd[5] = 64'h0000_0001_0000_0000; pos_sel = 3'd5;
        p_step = step[5];
        for (int k = 0; k < 50; k++) begin
            int_step = (k == 0);
            tick();
            checks++;
            if (obs_bus !== exp_bus) begin errors++; $display("FAIL t4_track cyc=%0d got=%h want=%h", cyc, obs_bus, exp_bus); end
            if (step[5] && !p_step) rises++;
            p_step = step[5];
        end
        checks++;
        if (overspeed[5] !== 1'b1) begin errors++; $display("FAIL t4_overspeed got=%b want=1", overspeed[5]); end
        checks++;
        if (rises != 1) begin errors++; $display("FAIL t4_pulses got=%0d want=1", rises); end
        checks++;
        if (pos_out !== 32'd1) begin errors++; $display("FAIL t4_pos got=%h want=1", pos_out); end
        err_clear = 1'b1; int_step = 1'b1;
        tick();
        checks++;
        if (overspeed[5] !== 1'b1) begin errors++; $display("FAIL t4_set_wins got=%b want=1", overspeed[5]); end
        int_step = 1'b0;
        tick();
        checks++;
        if (overspeed[5] !== 1'b0) begin errors++; $display("FAIL t4_clear got=%b want=0", overspeed[5]); end
        err_clear = 1'b0; spd[5] = 64'd0;
        for (int k = 0; k < 45; k++) begin
            tick();
            checks++;
            if (obs_bus !== exp_bus) begin errors++; $display("FAIL t4_drain cyc=%0d got=%h want=%h", cyc, obs_bus, exp_bus); end
        end
    endtask

    task automatic test_load();
        int rises = 0;
        logic p_step;
        spd[7] = 64'h0000_0001_0000_0000;
        pos_load = 1'b1; pos_sel = 3'd7; pos_in = 32'hFFFF_FFF0; int_step = 1'b1;
        tick();
        pos_load = 1'b0; int_step = 1'b0; spd[7] = 64'd0;
        p_step = step[7];
        tick();
        checks++;
        if (pos_out !== 32'hFFFF_FFF0) begin errors++; $display("FAIL t5_pos got=%h want=fffffff0", pos_out); end
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++;
            if (obs_bus !== exp_bus) begin errors++; $display("FAIL t5_track cyc=%0d got=%h want=%h", cyc, obs_bus, exp_bus); end
            if (step[7] && !p_step) rises++;
            p_step = step[7];
        end
        checks++;
        if (rises != 0) begin errors++; $display("FAIL t5_no_pulse got=%0d want=0", rises); end
    endtask

    task automatic test_reset_mid_pulse();
        int waited = 0;
        int rises = 0;
        logic [7:0] p_step;
        spd[1] = 64'h0000_0001_0000_0000; pos_sel = 3'd1;
        int_step = 1'b1; tick(); tick();
        int_step = 1'b0; spd[1] = 64'd0;
        while (!step[1] && waited < 40) begin tick(); waited++; end
        checks++;
        if (!step[1]) begin errors++; $display("FAIL t6_wait got=%b want=1 within 40 cycles", step[1]); end
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (step[1] !== 1'b1) begin errors++; $display("FAIL t6_high5 got=%b want=1", step[1]); end
        rst = 1'b1;
        tick();
        checks++;
        if ({step, dir, overrun, overspeed, active, pos_out} !== 65'd0)
            begin errors++; $display("FAIL t6_reset got=%h want=0", {step, dir, overrun, overspeed, active, pos_out}); end
        rst = 1'b0;
        p_step = step;
        for (int k = 0; k < 60; k++) begin
            tick();
            checks++;
            if (obs_bus !== exp_bus) begin errors++; $display("FAIL t6_track cyc=%0d got=%h want=%h", cyc, obs_bus, exp_bus); end
            if ((step & ~p_step) != 8'd0) rises++;
            p_step = step;
        end
        checks++;
        if (rises != 0) begin errors++; $display("FAIL t6_no_pending got=%0d want=0", rises); end
    endtask

    task automatic test_random();
        logic [63:0] mag;
        int ch;
        for (int k = 0; k < 4008; k++) begin
            if (k < 8 || $urandom_range(0, 99) == 0) begin
                ch = (k < 8) ? k : int'($urandom_range(0, 7));
                mag = {32'h0, $urandom()} >> $urandom_range(0, 4);
                if ($urandom_range(0, 15) == 0) mag = mag + 64'h0000_0001_0000_0000;
                spd[ch] = ($urandom_range(0, 1) == 1) ? (~mag + 64'd1) : mag;
            end
            int_step  = ($urandom_range(0, 5) == 0);
            pos_load  = ($urandom_range(0, 39) == 0);
            pos_sel   = 3'($urandom_range(0, 7));
            pos_in    = $urandom();
            err_clear = ($urandom_range(0, 49) == 0);
            tick();
            checks++;
            if (obs_bus !== exp_bus) begin errors++; $display("FAIL rand_track cyc=%0d got=%h want=%h", cyc, obs_bus, exp_bus); end
        end
        int_step = 1'b0; pos_load = 1'b0; err_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dir_setup();
        test_reverse();
        test_back_to_back();
        test_overspeed();
        test_load();
        test_reset_mid_pulse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
